// File: rtl/slv_reg_responder_pkg.sv
// Shared types and constants for the slv_reg_responder register responder.
package slv_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;
    localparam int BUS_OUT_W  = 5;

    function automatic logic even_parity(input logic [31:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/slv_regfile.sv
// DEPTH x DATA_W register storage: one synchronous write port, one combinational read port.
module slv_regfile #(
    parameter int DEPTH  = 12,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage array with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Out-of-range reads return zero rather than an undefined element
    always_comb begin
        if (int'(raddr) < DEPTH) begin
            rdata = mem_r[raddr];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/slv_reg_responder.sv
// Slave-side register responder for the slv_ valid/ready bus with programmable wait states.
// Optional macro SLV_RESP_PARITY_EN adds slv_rdata_par (even parity of slv_rdata).
module slv_reg_responder
    import slv_resp_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 slv_valid,
    input  logic                 slv_write,
    input  logic [ADDR_W-1:0]    slv_addr,
    input  logic [DATA_W-1:0]    slv_wdata,
    output logic [DATA_W-1:0]    slv_rdata,
`ifdef SLV_RESP_PARITY_EN
    output logic                 slv_rdata_par,
`endif
    output logic                 slv_ready,
    output logic                 slv_err,
    output logic [BUS_OUT_W-1:0] bus_out
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [3:0]        cnt_r;
    logic              req_write_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [DATA_W-1:0] req_wdata_r;

    logic              sel_write_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic              sel_in_range_s;
    logic              req_in_range_s;
    logic [DATA_W-1:0] mem_rdata_s;
    logic              ready_nxt_s;
    logic              err_nxt_s;
    logic [DATA_W-1:0] rdata_nxt_s;
    logic              we_s;

    slv_regfile #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_s),
        .waddr (req_addr_r),
        .wdata (req_wdata_r),
        .raddr (sel_addr_s),
        .rdata (mem_rdata_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (slv_valid) begin
                    state_nxt_s = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Response values; with zero wait states the live request feeds RESP directly
    always_comb begin
        if (state_r == IDLE) begin
            sel_write_s = slv_write;
            sel_addr_s  = slv_addr;
        end else begin
            sel_write_s = req_write_r;
            sel_addr_s  = req_addr_r;
        end
        sel_in_range_s = int'(sel_addr_s) < DEPTH;
        req_in_range_s = int'(req_addr_r) < DEPTH;
        ready_nxt_s    = (state_nxt_s == RESP) && (state_r != RESP);
        err_nxt_s      = ready_nxt_s && !sel_in_range_s;
        if (ready_nxt_s && !sel_write_s && sel_in_range_s) begin
            rdata_nxt_s = mem_rdata_s;
        end else begin
            rdata_nxt_s = '0;
        end
        we_s = (state_r == RESP) && req_write_r && req_in_range_s;
    end

    // Request capture, wait counter, handshake counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= 4'd0;
            req_write_r <= 1'b0;
            req_addr_r  <= '0;
            req_wdata_r <= '0;
            bus_out     <= '0;
            slv_ready   <= 1'b0;
            slv_err     <= 1'b0;
            slv_rdata   <= '0;
        end else begin
            if (state_r == IDLE && slv_valid) begin
                req_write_r <= slv_write;
                req_addr_r  <= slv_addr;
                req_wdata_r <= slv_wdata;
                cnt_r       <= CNT_INIT;
            end else if (state_r == WAIT && cnt_r != 4'd0) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (state_r == RESP) begin
                bus_out <= bus_out + BUS_OUT_W'(1);
            end
            slv_ready <= ready_nxt_s;
            slv_err   <= err_nxt_s;
            slv_rdata <= rdata_nxt_s;
        end
    end

`ifdef SLV_RESP_PARITY_EN
    // Parity registered alongside slv_rdata
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slv_rdata_par <= 1'b0;
        end else begin
            slv_rdata_par <= even_parity(32'(rdata_nxt_s));
        end
    end
`endif

endmodule

// File: tb/tb_slv_reg_responder.sv
// Randomized and directed bench for slv_reg_responder against a transaction-level model.
module tb_slv_reg_responder;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0, write = 1'b0;
    logic [3:0] addr = 4'd0, wdata = 4'd0;
    logic [3:0] rdata;
    logic       ready, err;
    logic [4:0] bus;
    logic       valid0 = 1'b0;
    logic [3:0] addr0 = 4'd0;
    logic [3:0] rdata0;
    logic       ready0, err0;
    logic [4:0] bus0;
`ifdef SLV_RESP_PARITY_EN
    logic       par, par0, last_par;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    slv_reg_responder #(.ADDR_W(4), .DATA_W(4), .DEPTH(12), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .slv_valid(valid), .slv_write(write),
        .slv_addr(addr), .slv_wdata(wdata), .slv_rdata(rdata),
`ifdef SLV_RESP_PARITY_EN
        .slv_rdata_par(par),
`endif
        .slv_ready(ready), .slv_err(err), .bus_out(bus)
    );

    slv_reg_responder #(.ADDR_W(4), .DATA_W(4), .DEPTH(12), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .slv_valid(valid0), .slv_write(1'b0),
        .slv_addr(addr0), .slv_wdata(4'd0), .slv_rdata(rdata0),
`ifdef SLV_RESP_PARITY_EN
        .slv_rdata_par(par0),
`endif
        .slv_ready(ready0), .slv_err(err0), .bus_out(bus0)
    );

    // Transaction-level model: one outstanding request, response cycle = capture edge + W
    logic [3:0] mem_m [16];
    int         cyc_m, resp_cyc_m, next_free_m;
    logic       pend_m, pw_m, perr_m;
    logic [3:0] pa_m, pd_m, prd_m;
    logic [4:0] bus_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_m       <= 0;
            resp_cyc_m  <= 0;
            next_free_m <= 0;
            pend_m      <= 1'b0;
            pw_m        <= 1'b0;
            perr_m      <= 1'b0;
            pa_m        <= 4'd0;
            pd_m        <= 4'd0;
            prd_m       <= 4'd0;
            bus_m       <= 5'd0;
            for (int i = 0; i < 16; i++) mem_m[i] <= 4'd0;
        end else begin
            cyc_m <= cyc_m + 1;
            if (pend_m && resp_cyc_m + 1 == cyc_m + 1) begin
                if (pw_m && pa_m < 4'd12) mem_m[pa_m] <= pd_m;
                bus_m  <= bus_m + 5'd1;
                pend_m <= 1'b0;
            end
            if (valid && cyc_m + 1 >= next_free_m) begin
                pend_m      <= 1'b1;
                resp_cyc_m  <= cyc_m + 1 + W;
                next_free_m <= cyc_m + 1 + W + 2;
                pw_m        <= write;
                pa_m        <= addr;
                pd_m        <= wdata;
                perr_m      <= (addr >= 4'd12);
                prd_m       <= (!write && addr < 4'd12) ? mem_m[addr] : 4'd0;
            end
        end
    end

    logic       exp_ready, exp_err;
    logic [3:0] exp_rdata;
    always_comb begin
        exp_ready = pend_m && (resp_cyc_m == cyc_m);
        exp_err   = exp_ready ? perr_m : 1'b0;
        exp_rdata = exp_ready ? prd_m : 4'd0;
    end

    // Per-cycle comparison of the main DUT against the model
    always @(negedge clk) begin
        if (rst_n) begin
            n_tests++;
            if (ready !== exp_ready || err !== exp_err || rdata !== exp_rdata || bus !== bus_m
`ifdef SLV_RESP_PARITY_EN
                || par !== ^exp_rdata
`endif
            ) begin
                n_fail++;
                $display("FAIL cycle_cmp @%0t: ready %b want %b, err %b want %b, rdata %h want %h, bus %0d want %0d",
                         $time, ready, exp_ready, err, exp_err, rdata, exp_rdata, bus, bus_m);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        valid0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Hold a request until the ready pulse; lat counts negedges from assertion to ready
    task automatic issue(input logic w, input logic [3:0] a, input logic [3:0] d,
                         output logic [3:0] rd, output logic er, output int lat);
        logic seen;
        seen = 1'b0;
        rd = 4'd0;
        er = 1'b0;
        lat = 0;
        @(negedge clk);
        valid = 1'b1; write = w; addr = a; wdata = d;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (ready === 1'b1) begin
                seen = 1'b1;
                rd = rdata;
                er = err;
`ifdef SLV_RESP_PARITY_EN
                last_par = par;
`endif
            end
        end
        valid = 1'b0;
        if (!seen) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    logic [3:0] rd;
    logic       er;
    int         lat;
    logic [7:0] pattern;

    initial begin
        do_reset();
        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, ready}, 32'd0);
        end
        chk("idle_bus", {27'd0, bus}, 32'd0);
        chk("idle_rdata", {28'd0, rdata}, 32'd0);

        // Zero-wait instance, four back-to-back reads with valid held
        pattern = 8'd0;
        @(negedge clk);
        valid0 = 1'b1; addr0 = 4'd2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pattern[i] = ready0;
        end
        valid0 = 1'b0;
        chk("w0_pattern", {24'd0, pattern}, 32'h55);
        chk("w0_bus", {27'd0, bus0}, 32'd4);

        // Write then read-back of address 3
        issue(1'b1, 4'h3, 4'hA, rd, er, lat);
        chk("wr3_latency", lat, 32'd3);
        chk("wr3_err", {31'd0, er}, 32'd0);
        @(negedge clk);
        chk("wr3_bus", {27'd0, bus}, 32'd1);
        issue(1'b0, 4'h3, 4'h0, rd, er, lat);
        chk("rd3_data", {28'd0, rd}, 32'hA);
        chk("rd3_err", {31'd0, er}, 32'd0);

        // Out-of-range write and read
        issue(1'b1, 4'hD, 4'h5, rd, er, lat);
        chk("wrD_err", {31'd0, er}, 32'd1);
        chk("wrD_rdata", {28'd0, rd}, 32'd0);
        issue(1'b0, 4'hD, 4'h0, rd, er, lat);
        chk("rdD_err", {31'd0, er}, 32'd1);
        chk("rdD_rdata", {28'd0, rd}, 32'd0);
        for (int a = 0; a < 12; a++) begin
            issue(1'b0, 4'(a), 4'h0, rd, er, lat);
            chk($sformatf("scan_%0d", a), {28'd0, rd}, (a == 3) ? 32'hA : 32'h0);
        end

`ifdef SLV_RESP_PARITY_EN
        issue(1'b1, 4'h7, 4'hB, rd, er, lat);
        issue(1'b0, 4'h7, 4'h0, rd, er, lat);
        chk("par_rdata", {28'd0, rd}, 32'hB);
        chk("par_bit", {31'd0, last_par}, 32'd1);
`endif

        // Reset during the wait phase of a write
        @(negedge clk);
        valid = 1'b1; write = 1'b1; addr = 4'h5; wdata = 4'h7;
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_ready", {31'd0, ready}, 32'd0);
        end
        chk("abort_bus", {27'd0, bus}, 32'd0);
        issue(1'b0, 4'h5, 4'h0, rd, er, lat);
        chk("abort_rd5", {28'd0, rd}, 32'd0);

        // Handshake counter wrap
        do_reset();
        for (int i = 0; i < 33; i++) begin
            issue(1'b1, 4'($urandom_range(0, 11)), 4'($urandom), rd, er, lat);
        end
        @(negedge clk);
        chk("bus_wrap", {27'd0, bus}, 32'd1);

        // Randomized traffic, including input changes and drops while busy
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 3) != 0);
            write = 1'($urandom);
            addr  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            wdata = 4'($urandom);
            if (i == 300) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/slv_reg_responder.md
Name: slv_reg_responder

Overview:
- Sequential responder for the slv_/mst_ valid/ready bus. It is the slave-side counterpart to the master initiator.
- Holds a small register file and answers read and write requests after a programmable number of wait states, with a one-cycle ready pulse.
- Sits under an aggregate top, with its slv_* ports wired directly to an initiator's mst_* ports. bus_out feeds the top-level OR-merged status.

Parameters:
- ADDR_W, 4, address width.
- DATA_W, 4, data width.
- DEPTH, 12, number of implemented registers; addresses >= DEPTH are out of range.
- WAIT_CYCLES, 2, wait states between request capture and response; legal range 0..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- slv_valid  input  1  request valid; held by the initiator until slv_ready is seen.
- slv_write  input  1  1 = write, 0 = read; qualified by slv_valid.
- slv_addr  input  ADDR_W  register address.
- slv_wdata  input  DATA_W  write data.
- slv_rdata  output  DATA_W  read data; valid only while slv_ready=1.
- slv_ready  output  1  one-cycle response pulse.
- slv_err  output  1  out-of-range response flag; valid only while slv_ready=1.
- bus_out  output  5  count of completed handshakes, wraps 31->0.

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous assert, synchronous deassert, active-low.
- Reset values: state=IDLE, slv_ready=0, slv_err=0, slv_rdata=0, bus_out=0, wait counter=0, all DEPTH registers=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a clk edge with slv_valid=1, capture write/addr/wdata into request registers.
  - WAIT_CYCLES>0: go to WAIT, cnt=WAIT_CYCLES-1.
  - WAIT_CYCLES=0: go directly to RESP.
- WAIT: if cnt==0, go to RESP; else cnt-=1. Input changes are ignored; captured values only.
- Transition into RESP:
  - Register slv_rdata = mem[addr] for an in-range read, else 0.
  - Register slv_err = (addr >= DEPTH).
- RESP: slv_ready=1 for exactly this one cycle.
  - At the closing edge, an in-range write commits mem[addr]=wdata.
  - Out-of-range writes are dropped.
  - bus_out increments mod 32.
  - Next state is IDLE.
- Latency: slv_ready is high in the cycle after edge E0+WAIT_CYCLES, where E0 is the capture edge.
- Back-to-back requests: slv_valid still high in the IDLE cycle after RESP is a new request and is captured at that edge. Minimum transaction period is WAIT_CYCLES+2 cycles.
- Read-after-write: a read issued after a write response returns the new data.
- slv_rdata and slv_err return to 0 when leaving RESP. Outputs are registered only; there is no combinational path from slv_* inputs.
- Reset mid-transaction: abort immediately to the reset values. A pending write is not committed.
- slv_valid dropping during WAIT (protocol violation): the transaction still completes with the captured request.

Optional Feature:
- Macro: SLV_RESP_PARITY_EN.
- Defined: extra output slv_rdata_par (1 bit) = even parity (^) of the registered slv_rdata. It is registered in the same edge as slv_rdata and reset to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package slv_resp_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - localparam widths ADDR_W_DEF=4 and DATA_W_DEF=4;
  - BUS_OUT_W=5.
- One sub-module, slv_regfile:
  - DEPTH x DATA_W storage with async reset to 0;
  - one write port (we, waddr, wdata);
  - one combinational read port.
- The FSM, wait counter and handshake counter stay in slv_reg_responder.

Test Plan:
- Reset then idle, 10 cycles with slv_valid=0 -> slv_ready=0, bus_out=0, slv_rdata=0 throughout.
- Write addr 4'h3 data 4'hA, WAIT_CYCLES=2 -> slv_ready pulses once, 3 cycles after the capture edge, with slv_err=0 and bus_out=1. A following read of 4'h3 returns slv_rdata=4'hA with slv_err=0.
- Write then read addr 4'hD (out of range, DEPTH=12) -> both responses have slv_err=1 and slv_rdata=0; all 12 registers are unchanged (read back 0).
- WAIT_CYCLES=0 with slv_valid held high for 4 back-to-back reads -> slv_ready pulses every 2nd cycle and bus_out=4.
- 33 completed transactions -> bus_out wraps to 1.
- Assert rst_n=0 during WAIT of a write to 4'h5=4'h7 -> slv_ready never pulses; a later read of 4'h5 returns 0.
- With SLV_RESP_PARITY_EN, read data 4'hB -> slv_rdata_par=1.
